// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- FIFO-buffered UART transmitter (8 data bits, 1 stop bit)
//
// Bytes written via data_in/wr_en are queued in a FIFO of FIFO_DEPTH entries.
// They are then shifted out LSB first on tx. Each bit lasts CLK_FREQ/BAUD_RATE
// clocks. Frames in the queue follow each other with no idle gap.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> an even-parity bit is inserted after the data bits (8E1)
//   undefined -> 8N1 frame, no parity logic
//
// Parameters:
//   CLK_FREQ    system clock frequency in Hz
//   BAUD_RATE   serial bit rate in bit/s (CLK_FREQ/BAUD_RATE <= 65535)
//   FIFO_DEPTH  transmit FIFO entries, power of two, 2..16
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   data_in  in   [7:0] byte to queue
//   wr_en    in   write strobe; accepted when full is low
//   full     out  FIFO holds FIFO_DEPTH bytes; further writes dropped
//   tx       out  serial line, idle high, registered
//   tx_busy  out  high while a frame is on the line
//   done     out  one-cycle pulse on the last clock of each stop bit
// -----------------------------------------------------------------------------
module uart_tx #(
   parameter int CLK_FREQ   = 1_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       wr_en,
   output logic       full,
   output logic       tx,
   output logic       tx_busy,
   output logic       done
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [15:0] BIT_LAST = 16'(CLK_FREQ / BAUD_RATE - 1);
   localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   // ---------------------------------------------------------------- FIFO
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q;
   logic          push, pop, empty;
   logic [7:0]    head;

   assign full  = (cnt_q == DEPTH_C);
   assign empty = (cnt_q == '0);
   assign push  = wr_en && !full;    // a full FIFO drops the write even if a pop happens too
   assign head  = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
         else if (pop && !push) cnt_q <= cnt_q - (AW+1)'(1);
      end
   end

   // ---------------------------------------------------------------- FSM
   state_t      state_q;
   logic [15:0] bit_cnt_q;
   logic [2:0]  bit_idx_q;
   logic [7:0]  shift_q;
   logic        tx_q, busy_q, done_q;
   logic        bit_end;
`ifdef UART_TX_PARITY_EN
   logic        parity_q;
`endif

   assign bit_end = (bit_cnt_q == BIT_LAST);
   // Pop when idle, or on the last stop-bit clock so the next frame follows without a gap.
   assign pop     = !empty && ((state_q == IDLE) || (state_q == STOP && bit_end));

   // Outputs are registered from the current state. So the line lags the state by one
   // clock. The bit lengths stay exact, and done lines up with the last stop-bit clock on tx.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         busy_q <= (state_q != IDLE);
         case (state_q)
            IDLE: begin
               tx_q      <= 1'b1;
               bit_cnt_q <= '0;
               if (pop) begin
                  shift_q <= head;
`ifdef UART_TX_PARITY_EN
                  parity_q <= ^head;
`endif
                  state_q <= START;
               end
            end
            START: begin
               tx_q <= 1'b0;
               if (bit_end) begin
                  bit_cnt_q <= '0;
                  bit_idx_q <= '0;
                  state_q   <= DATA;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 16'd1;
               end
            end
            DATA: begin
               tx_q <= shift_q[0];
               if (bit_end) begin
                  bit_cnt_q <= '0;
                  shift_q   <= {1'b0, shift_q[7:1]};
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_q + 16'd1;
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               tx_q <= parity_q;
               if (bit_end) begin
                  bit_cnt_q <= '0;
                  state_q   <= STOP;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 16'd1;
               end
            end
`endif
            STOP: begin
               tx_q <= 1'b1;
               if (bit_end) begin
                  bit_cnt_q <= '0;
                  done_q    <= 1'b1;
                  if (pop) begin
                     shift_q <= head;
`ifdef UART_TX_PARITY_EN
                     parity_q <= ^head;
`endif
                     state_q <= START;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_q + 16'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx      = tx_q;
   assign tx_busy = busy_q;
   assign done    = done_q;

endmodule
